i2c_ctrl_writer: RTL
====================

// Module: i2c_ctrl_writer
// PURPOSE
//  Single-master I2C controller issuing one write transaction: START, 7-bit address + W,
//  one data byte, STOP. It is the initiator end of the link whose target decodes the
//  coilgun control register. It sits on the bench/host side and drives the shared SCL/SDA.
//  Open-drain only: a line is pulled low when its OE is 1 and released (pulled up) otherwise.
// PARAMETERS
//  CLK_DIV  4  I_clk cycles per SCL quarter-period; legal range >= 4.
// PORTS
//  I_clk    in   1  system clock; all logic is in this single domain.
//  I_rstn   in   1  asynchronous, active-low reset.
//  I_start  in   1  request pulse; sampled only while O_busy=0.
//  I_addr   in   7  target address, latched on an accepted I_start.
//  I_data   in   8  data byte, latched on an accepted I_start.
//  I_scl    in   1  SCL line readback (async); used for clock-stretch detection.
//  I_sda    in   1  SDA line readback (async); used for ACK sampling.
//  OE_scl   out  1  1 = pull SCL low.
//  OE_sda   out  1  1 = pull SDA low.
//  O_busy   out  1  high from the cycle after acceptance until O_done.
//  O_done   out  1  one-cycle pulse when STOP completes.
//  O_nack   out  1  valid with O_done; held until the next accepted I_start.
// BEHAVIOUR
//  - Reset (async, immediate): OE_scl=0, OE_sda=0, O_busy=0, O_done=0, O_nack=0, state IDLE,
//    quarter counter 0. Reset mid-transfer releases both lines; no STOP is generated.
//  - I_scl/I_sda pass through 2-flop synchronizers before use.
//  - Accept: I_start=1 && O_busy=0 -> latch {I_addr,1'b0} as the shift byte and I_data;
//    O_busy=1 next cycle. I_start while busy is ignored.
//  - Quarter tick: counter runs 0..CLK_DIV-1 and pulses at CLK_DIV-1. Each bit takes 4
//    quarters q0..q3: q0 and q1 hold SCL low, with SDA updated at the start of q0; q2 and q3
//    release SCL; SDA is sampled at the start of q3.
//  - Clock stretch: at the end of q2, if synced SCL=0, the counter holds until synced SCL=1.
//  - FSM: IDLE -> START -> ADDR(8 bits) -> ACK_A -> DATA(8 bits) -> ACK_D -> STOP -> IDLE.
//    START (4 quarters): q0/q1 both lines released; q2 SDA low; q3 SCL low.
//    ADDR/DATA: MSB first; a 0 bit sets OE_sda=1, a 1 bit sets OE_sda=0.
//    ACK_A/ACK_D: OE_sda=0; synced SDA=1 at q3 is a NACK -> set O_nack, go to STOP.
//    A NACK in ACK_A skips DATA.
//    STOP (4 quarters): q0/q1 SCL low and SDA low; q2 SCL released; q3 SDA released.
//  - Latency without stretching: O_done is asserted 80*CLK_DIV+1 cycles after the accept
//    cycle (44*CLK_DIV+1 on an address NACK). O_busy falls in the same cycle as O_done.
//  - On return to IDLE both OE outputs are 0. No arbitration: single master only.
// STRUCTURE
//  - Shared include i2c_defs.vh: FSM state encodings, I2C_RW_WRITE=1'b0, ACK=1'b0/NACK=1'b1.
//    The target core uses the same include.
//  - Sub-module i2c_qtick: CLK_DIV quarter-tick generator with a hold input for stretching.
//  - Top level holds the FSM, the 8-bit shift register, the bit counter (0..7) and the
//    synchronizers.
// TESTING
//  - Pullup model plus a target BFM that ACKs addr 0x02. Start addr=0x02 data=0xA5 ->
//    bus shows S,0x04,ACK,0xA5,ACK,P; O_done at cycle 321 (CLK_DIV=4); O_nack=0.
//  - addr=0x05 with BFM not ACKing -> S,0x0A,NACK,P; O_done at cycle 177; O_nack=1;
//    no data bits on the bus.
//  - BFM holds SCL low 50 cycles during the bit-3 q2 of DATA -> transfer resumes intact;
//    O_done is delayed by >=50 cycles; the byte is received correctly.
//  - I_start pulsed again mid-transfer with data=0xFF -> ignored; only the first byte appears.
//  - I_rstn low during the DATA phase -> OE_scl=OE_sda=0 in the same cycle; O_busy=0;
//    a fresh start after reset completes normally.
//  - Back-to-back: I_start in the cycle after O_done -> accepted; second transaction correct.

Source files
------------

// File: rtl/i2c_ctrl_writer_pkg.sv
// Shared definitions for the single-byte I2C write controller: FSM encodings and bus constants.
package i2c_ctrl_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_ACK_A = 3'd3,
    ST_DATA  = 3'd4,
    ST_ACK_D = 3'd5,
    ST_STOP  = 3'd6
  } state_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  // Open-drain: a 0 on the wire means pull low, a 1 means release.
  function automatic logic sda_oe_for_bit(input logic b);
    return ~b;
  endfunction

endpackage

// File: rtl/i2c_ctrl_writer_if.sv
// Host request/status and open-drain bus signals of the I2C write controller.
interface i2c_ctrl_writer_if;
  logic       I_start;
  logic [6:0] I_addr;
  logic [7:0] I_data;
  logic       I_scl;
  logic       I_sda;
  logic       OE_scl;
  logic       OE_sda;
  logic       O_busy;
  logic       O_done;
  logic       O_nack;

  modport master (
    input  I_start, I_addr, I_data, I_scl, I_sda,
    output OE_scl, OE_sda, O_busy, O_done, O_nack
  );

  modport slave (
    output I_start, I_addr, I_data, I_scl, I_sda,
    input  OE_scl, OE_sda, O_busy, O_done, O_nack
  );
endinterface

// File: rtl/i2c_ctrl_writer_qtick.sv
// SCL quarter-period tick generator; hold freezes the counter at its terminal count.
module i2c_ctrl_writer_qtick #(
  parameter int CLK_DIV = 4
) (
  input  logic I_clk,
  input  logic I_rstn,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      if (!hold) cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CNT_MAX) && !hold;

endmodule

// File: rtl/i2c_ctrl_writer.sv
// Single-master I2C controller: START, address+W, one data byte, STOP, with ACK checks
// and SCL clock-stretch support. Both lines are driven open-drain through OE outputs.
module i2c_ctrl_writer
  import i2c_ctrl_writer_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input logic               I_clk,
  input logic               I_rstn,
  i2c_ctrl_writer_if.master bus
);

  state_t     state;
  logic [1:0] qtr;
  logic [2:0] bit_cnt;
  logic [7:0] sreg;
  logic [7:0] data_q;
  logic       ack_bit;
  logic       oe_scl, oe_sda, busy, done, nack;
  logic [1:0] scl_meta, sda_meta;
  logic       scl_sync, sda_sync;
  logic       tick, hold;
  logic       load_addr, load_data, shift_bit;

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      scl_meta <= 2'b11;
      sda_meta <= 2'b11;
    end else begin
      scl_meta <= {scl_meta[0], bus.I_scl};
      sda_meta <= {sda_meta[0], bus.I_sda};
    end
  end

  assign scl_sync = scl_meta[1];
  assign sda_sync = sda_meta[1];

  // A target stretching SCL is only noticed at the end of the high-going quarter.
  assign hold = (qtr == 2'd2) && !scl_sync;

  i2c_ctrl_writer_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .I_clk  (I_clk),
    .I_rstn (I_rstn),
    .en     (busy),
    .hold   (hold),
    .tick   (tick)
  );

  assign load_addr = (state == ST_IDLE) && bus.I_start;
  assign load_data = tick && (state == ST_ACK_A) && (qtr == 2'd3) && (ack_bit == I2C_ACK);
  assign shift_bit = tick && ((state == ST_ADDR) || (state == ST_DATA)) &&
                     (qtr == 2'd3) && (bit_cnt != 3'd7);

  always_ff @(posedge I_clk) begin
    if (load_addr) begin
      sreg   <= {bus.I_addr, I2C_RW_WRITE};
      data_q <= bus.I_data;
    end else if (load_data) begin
      sreg <= data_q;
    end else if (shift_bit) begin
      sreg <= {sreg[6:0], 1'b0};
    end
  end

  // Outputs are set on the tick that opens the quarter they belong to.
  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state   <= ST_IDLE;
      qtr     <= 2'd0;
      bit_cnt <= 3'd0;
      ack_bit <= I2C_ACK;
      oe_scl  <= 1'b0;
      oe_sda  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        oe_scl <= 1'b0;
        oe_sda <= 1'b0;
        if (bus.I_start) begin
          state   <= ST_START;
          qtr     <= 2'd0;
          bit_cnt <= 3'd0;
          ack_bit <= I2C_ACK;
          busy    <= 1'b1;
          nack    <= 1'b0;
        end
      end else if (tick) begin
        qtr <= qtr + 2'd1;
        case (state)
          ST_START: begin
            case (qtr)
              2'd1: oe_sda <= 1'b1;
              2'd2: oe_scl <= 1'b1;
              2'd3: begin
                state  <= ST_ADDR;
                oe_sda <= sda_oe_for_bit(sreg[7]);
              end
              default: ;
            endcase
          end
          ST_ADDR, ST_DATA: begin
            case (qtr)
              2'd1: oe_scl <= 1'b0;
              2'd3: begin
                oe_scl <= 1'b1;
                if (bit_cnt == 3'd7) begin
                  bit_cnt <= 3'd0;
                  state   <= (state == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
                  oe_sda  <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  oe_sda  <= sda_oe_for_bit(sreg[6]);
                end
              end
              default: ;
            endcase
          end
          ST_ACK_A, ST_ACK_D: begin
            case (qtr)
              2'd1: oe_scl <= 1'b0;
              2'd2: ack_bit <= sda_sync;
              2'd3: begin
                oe_scl <= 1'b1;
                if ((state == ST_ACK_A) && (ack_bit == I2C_ACK)) begin
                  state  <= ST_DATA;
                  oe_sda <= sda_oe_for_bit(data_q[7]);
                end else begin
                  state  <= ST_STOP;
                  oe_sda <= 1'b1;
                  nack   <= (ack_bit == I2C_NACK);
                end
              end
              default: ;
            endcase
          end
          ST_STOP: begin
            case (qtr)
              2'd1: oe_scl <= 1'b0;
              2'd2: oe_sda <= 1'b0;
              2'd3: begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: ;
            endcase
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.OE_scl = oe_scl;
  assign bus.OE_sda = oe_sda;
  assign bus.O_busy = busy;
  assign bus.O_done = done;
  assign bus.O_nack = nack;

endmodule
